// File: rtl/cnn_img_feeder.sv
// cnn_img_feeder: host-side driver for the top_cnn inference core.
// Collects N_PIX pixels (one per accepted cycle) into a packed image bus, launches the core
// with a one-cycle start pulse, waits for a rising edge of the core's ready, and then holds
// the captured prediction until the host acknowledges it. A watchdog turns a hung
// inference into an error result (all-ones number, res_err set).
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_pix_in         pixel data, PIX_W bits
//   i_pix_valid      pixel valid
//   o_pix_ready      feeder accepts a pixel (LOAD only)
//   o_cnn_img        packed image, pixel k at [PIX_W*k +: PIX_W]
//   o_cnn_valid      one-cycle start pulse to the core
//   i_cnn_ready      core done (pulse or level; rising edge counts)
//   i_cnn_predict    core prediction
//   o_res_number     captured prediction (or all ones on timeout)
//   o_res_valid      result available
//   o_res_err        result came from the watchdog
//   i_res_ack        host consumes the result
//   o_busy           high in FIRE and WAIT
module cnn_img_feeder #(
   parameter int unsigned PIX_W   = 8,
   parameter int unsigned N_PIX   = 144,
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [PIX_W-1:0]       i_pix_in,
   input  logic                   i_pix_valid,
   output logic                   o_pix_ready,
   output logic [PIX_W*N_PIX-1:0] o_cnn_img,
   output logic                   o_cnn_valid,
   input  logic                   i_cnn_ready,
   input  logic [31:0]            i_cnn_predict,
   output logic [31:0]            o_res_number,
   output logic                   o_res_valid,
   output logic                   o_res_err,
   input  logic                   i_res_ack,
   output logic                   o_busy
);

   localparam int unsigned IMG_W = PIX_W * N_PIX;
   localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_LOAD,
      S_FIRE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_d;
   logic [7:0]        r_pix_cnt;
   logic [WD_W-1:0]   r_wdog;
   logic              r_rdy_q;
   logic [IMG_W-1:0]  r_img;
   logic [31:0]       r_res_number;
   logic              r_res_err;
   logic              r_res_valid;

   logic              w_accept;
   logic              w_last;
   logic              w_rise;
   logic              w_to;

   // Edge detect so a ready level left high from the previous image cannot complete this one.
   assign w_rise = i_cnn_ready & ~r_rdy_q;
   assign w_last = (r_pix_cnt == 8'(N_PIX - 1));
   assign w_to   = (r_wdog == WD_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      o_pix_ready = 1'b0;
      o_cnn_valid = 1'b0;
      o_busy      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_LOAD: begin
            o_pix_ready = 1'b1;
            w_accept    = i_pix_valid;
            if (i_pix_valid && w_last) begin
               w_state_d = S_FIRE;
            end
         end
         S_FIRE: begin
            o_cnn_valid = 1'b1;
            o_busy      = 1'b1;
            w_state_d   = S_WAIT;
         end
         S_WAIT: begin
            o_busy = 1'b1;
            if (w_rise || w_to) begin
               w_state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (i_res_ack) begin
               w_state_d = S_LOAD;
            end
         end
         default: w_state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pix_cnt    <= '0;
         r_wdog       <= '0;
         r_rdy_q      <= 1'b0;
         r_img        <= '0;
         r_res_number <= '0;
         r_res_err    <= 1'b0;
         r_res_valid  <= 1'b0;
      end else begin
         r_rdy_q     <= i_cnn_ready;
         r_res_valid <= (w_state_d == S_DONE);

         if (w_accept) begin
            r_img[PIX_W*r_pix_cnt +: PIX_W] <= i_pix_in;
            r_pix_cnt <= w_last ? 8'd0 : r_pix_cnt + 8'd1;
         end

         if (r_state == S_FIRE) begin
            r_wdog <= '0;
         end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + WD_W'(1);
         end

         // Completion has priority over the watchdog in the same cycle.
         if (r_state == S_WAIT) begin
            if (w_rise) begin
               r_res_number <= i_cnn_predict;
               r_res_err    <= 1'b0;
            end else if (w_to) begin
               r_res_number <= 32'hFFFF_FFFF;
               r_res_err    <= 1'b1;
            end
         end
      end
   end

   assign o_cnn_img    = r_img;
   assign o_res_number = r_res_number;
   assign o_res_err    = r_res_err;
   assign o_res_valid  = r_res_valid;

endmodule

// File: tb/tb_cnn_img_feeder.sv
// Directed self-checking bench for cnn_img_feeder. Instance a uses the default watchdog;
// instance b uses TIMEOUT = 20 and never sees a ready, to exercise the error path.
module tb_cnn_img_feeder;

   localparam int unsigned PIX_W = 8;
   localparam int unsigned N_PIX = 144;
   localparam int unsigned IMG_W = PIX_W * N_PIX;

   logic             clk;
   logic             rst;

   logic [7:0]       pix_in_a;
   logic             pix_valid_a;
   logic             pix_ready_a;
   logic [IMG_W-1:0] cnn_img_a;
   logic             cnn_valid_a;
   logic             cnn_ready_a;
   logic [31:0]      cnn_predict_a;
   logic [31:0]      res_number_a;
   logic             res_valid_a;
   logic             res_err_a;
   logic             res_ack_a;
   logic             busy_a;

   logic [7:0]       pix_in_b;
   logic             pix_valid_b;
   logic             pix_ready_b;
   logic [IMG_W-1:0] cnn_img_b;
   logic             cnn_valid_b;
   logic             cnn_ready_b;
   logic [31:0]      cnn_predict_b;
   logic [31:0]      res_number_b;
   logic             res_valid_b;
   logic             res_err_b;
   logic             res_ack_b;
   logic             busy_b;

   int n_chk;
   int n_err;

   cnn_img_feeder #(
      .PIX_W   (PIX_W),
      .N_PIX   (N_PIX),
      .TIMEOUT (100000)
   ) u_dut_a (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pix_in      (pix_in_a),
      .i_pix_valid   (pix_valid_a),
      .o_pix_ready   (pix_ready_a),
      .o_cnn_img     (cnn_img_a),
      .o_cnn_valid   (cnn_valid_a),
      .i_cnn_ready   (cnn_ready_a),
      .i_cnn_predict (cnn_predict_a),
      .o_res_number  (res_number_a),
      .o_res_valid   (res_valid_a),
      .o_res_err     (res_err_a),
      .i_res_ack     (res_ack_a),
      .o_busy        (busy_a)
   );

   cnn_img_feeder #(
      .PIX_W   (PIX_W),
      .N_PIX   (N_PIX),
      .TIMEOUT (20)
   ) u_dut_b (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pix_in      (pix_in_b),
      .i_pix_valid   (pix_valid_b),
      .o_pix_ready   (pix_ready_b),
      .o_cnn_img     (cnn_img_b),
      .o_cnn_valid   (cnn_valid_b),
      .i_cnn_ready   (cnn_ready_b),
      .i_cnn_predict (cnn_predict_b),
      .o_res_number  (res_number_b),
      .o_res_valid   (res_valid_b),
      .o_res_err     (res_err_b),
      .i_res_ack     (res_ack_b),
      .o_busy        (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pix_a(input int k);
      return 32'(cnn_img_a[PIX_W*k +: PIX_W]);
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic check_reset_a(input string tag);
      chk({tag, "_pix_ready"}, 32'(pix_ready_a), 32'd1);
      chk({tag, "_cnn_valid"}, 32'(cnn_valid_a), 32'd0);
      chk({tag, "_busy"},      32'(busy_a),      32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid_a), 32'd0);
      chk({tag, "_res_err"},   32'(res_err_a),   32'd0);
      chk({tag, "_res_num"},   res_number_a,     32'd0);
      chk({tag, "_img_zero"},  32'(|cnn_img_a),  32'd0);
   endtask

   // Feeds n pixels of value (k + base) into instance a; returns cycles where cnn_valid was seen.
   task automatic feed_a(input bit gapped, input int base, input int n, output int early_fire);
      int k;
      int cyc;
      k = 0;
      cyc = 0;
      early_fire = 0;
      while (k < n && cyc < 2000) begin
         step();
         if (cnn_valid_a) early_fire++;
         if (gapped && (cyc % 2 == 1)) begin
            pix_valid_a = 1'b0;
         end else begin
            pix_valid_a = 1'b1;
            pix_in_a    = 8'(k + base);
         end
         if (pix_valid_a && pix_ready_a) k++;
         cyc++;
      end
      chk("feed_count", 32'(k), 32'(n));
   endtask

   task automatic ack_a(input string tag);
      step();
      res_ack_a = 1'b1;
      step();
      res_ack_a = 1'b0;
      chk({tag, "_ack_res_valid"}, 32'(res_valid_a), 32'd0);
      chk({tag, "_ack_pix_ready"}, 32'(pix_ready_a), 32'd1);
   endtask

   initial begin
      int early;
      int bad;
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      pix_in_a = '0; pix_valid_a = 1'b0; cnn_ready_a = 1'b0; cnn_predict_a = '0; res_ack_a = 1'b0;
      pix_in_b = '0; pix_valid_b = 1'b0; cnn_ready_b = 1'b0; cnn_predict_b = '0; res_ack_b = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      check_reset_a("rst0");

      // Normal inference: contiguous pixels, ready 50 cycles after the start pulse.
      feed_a(1'b0, 0, 144, early);
      chk("s1_early_fire", 32'(early), 32'd0);
      step();
      pix_valid_a = 1'b0;
      chk("s1_cnn_valid", 32'(cnn_valid_a), 32'd1);
      chk("s1_busy_fire", 32'(busy_a), 32'd1);
      chk("s1_img_lo", pix_a(0), 32'd0);
      chk("s1_img_hi", pix_a(143), 32'd143);
      step();
      chk("s1_single_pulse", 32'(cnn_valid_a), 32'd0);
      chk("s1_busy_wait", 32'(busy_a), 32'd1);
      chk("s1_pix_ready_wait", 32'(pix_ready_a), 32'd0);
      for (int i = 0; i < 49; i++) step();
      chk("s1_no_result_yet", 32'(res_valid_a), 32'd0);
      cnn_ready_a = 1'b1;
      cnn_predict_a = 32'd7;
      step();
      chk("s1_res_valid", 32'(res_valid_a), 32'd1);
      chk("s1_res_num", res_number_a, 32'd7);
      chk("s1_res_err", 32'(res_err_a), 32'd0);
      chk("s1_busy_done", 32'(busy_a), 32'd0);
      ack_a("s1");

      // Gapped input with ready left high from the previous image (stale level).
      cnn_predict_a = 32'd9;
      feed_a(1'b1, 0, 144, early);
      chk("s2_early_fire", 32'(early), 32'd0);
      step();
      pix_valid_a = 1'b0;
      chk("s2_cnn_valid", 32'(cnn_valid_a), 32'd1);
      chk("s2_img_lo", pix_a(0), 32'd0);
      chk("s2_img_mid", pix_a(77), 32'd77);
      chk("s2_img_hi", pix_a(143), 32'd143);
      for (int i = 0; i < 5; i++) step();
      chk("s3_stale_ignored", 32'(res_valid_a), 32'd0);
      cnn_ready_a = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("s3_still_waiting", 32'(res_valid_a), 32'd0);
      cnn_ready_a = 1'b1;
      cnn_predict_a = 32'd3;
      step();
      cnn_ready_a = 1'b0;
      chk("s3_res_valid", 32'(res_valid_a), 32'd1);
      chk("s3_res_num", res_number_a, 32'd3);
      chk("s3_res_err", 32'(res_err_a), 32'd0);

      // Result hold and back-pressure: no ack for 30 cycles while pixels are offered.
      bad = 0;
      pix_valid_a = 1'b1;
      pix_in_a = 8'hAA;
      cnn_predict_a = 32'd99;
      for (int i = 0; i < 30; i++) begin
         step();
         if (pix_ready_a !== 1'b0 || res_valid_a !== 1'b1 || res_number_a !== 32'd3 ||
             res_err_a !== 1'b0) bad++;
      end
      chk("s5_hold_violations", 32'(bad), 32'd0);
      pix_valid_a = 1'b0;
      ack_a("s5");
      feed_a(1'b0, 5, 144, early);
      chk("s5_early_fire", 32'(early), 32'd0);
      step();
      pix_valid_a = 1'b0;
      chk("s5_cnn_valid", 32'(cnn_valid_a), 32'd1);
      chk("s5_img_lo", pix_a(0), 32'd5);
      chk("s5_img_hi", pix_a(143), 32'd148);
      for (int i = 0; i < 3; i++) step();
      cnn_ready_a = 1'b1;
      cnn_predict_a = 32'd11;
      step();
      cnn_ready_a = 1'b0;
      chk("s5_res_num", res_number_a, 32'd11);
      chk("s5_res_valid", 32'(res_valid_a), 32'd1);
      ack_a("s5b");

      // Reset after 70 pixels, then a full image must need all 144 pixels.
      feed_a(1'b0, 1, 70, early);
      step();
      pix_valid_a = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_a("s6_load");
      feed_a(1'b0, 0, 144, early);
      chk("s6_no_spurious_fire", 32'(early), 32'd0);
      step();
      pix_valid_a = 1'b0;
      chk("s6_cnn_valid", 32'(cnn_valid_a), 32'd1);
      step();
      chk("s6_in_wait", 32'(busy_a), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_a("s6_wait");

      // Full image with the earliest possible completion after the reset.
      feed_a(1'b0, 0, 144, early);
      chk("s6b_no_spurious_fire", 32'(early), 32'd0);
      step();
      pix_valid_a = 1'b0;
      chk("s6b_cnn_valid", 32'(cnn_valid_a), 32'd1);
      step();
      chk("s6b_first_wait", 32'(busy_a), 32'd1);
      cnn_ready_a = 1'b1;
      cnn_predict_a = 32'd6;
      step();
      cnn_ready_a = 1'b0;
      chk("s6b_res_valid", 32'(res_valid_a), 32'd1);
      chk("s6b_res_num", res_number_a, 32'd6);
      chk("s6b_res_err", 32'(res_err_a), 32'd0);
      ack_a("s6b");

      // Timeout on instance b: ready never rises.
      chk("s4_pix_ready", 32'(pix_ready_b), 32'd1);
      for (int k = 0; k < 144; k++) begin
         step();
         pix_valid_b = 1'b1;
         pix_in_b = 8'(k);
      end
      step();
      pix_valid_b = 1'b0;
      chk("s4_cnn_valid", 32'(cnn_valid_b), 32'd1);
      step();
      chk("s4_wait_entered", 32'(busy_b), 32'd1);
      for (int i = 0; i < 19; i++) step();
      chk("s4_not_yet", 32'(res_valid_b), 32'd0);
      step();
      chk("s4_res_valid", 32'(res_valid_b), 32'd1);
      chk("s4_res_num", res_number_b, 32'hFFFF_FFFF);
      chk("s4_res_err", 32'(res_err_b), 32'd1);
      chk("s4_busy_done", 32'(busy_b), 32'd0);
      res_ack_b = 1'b1;
      step();
      res_ack_b = 1'b0;
      chk("s4_ack", 32'(res_valid_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
